// File: rtl/alg_amba_vip_base_stats_window_ctrl.sv
// alg_amba_vip_base_stats_window_ctrl
//
// Measurement-window scheduler for NB_CH delay-statistics channels. It runs a
// programmable window and pulses the per-channel counter clear. At each window
// end it snapshots every channel's totals into a shadow. It then serializes the
// shadow channel by channel on a valid/ready readout port, so the counters can
// keep running while the previous window drains.
//
// Optional feature: define ALG_STATS_WIN_AVG_EN to add a serial restoring
// divider that produces rd_avg = delay_total / nb_request for each word.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   cfg_window_len     window length in cycles (0 treated as 1), sampled on start
//   cfg_single         1: one window then idle, 0: back-to-back windows
//   start, stop        control pulses
//   st_delay_total     per-channel delay sums   (ch i at [64*i+:64])
//   st_nb_request      per-channel request counts (ch i at [56*i+:56])
//   st_err             per-channel error flags  (ch i at [4*i+:4])
//   cnt_rst            registered per-channel counter clear
//   running            high while clearing or running a window
//   rd_*               snapshot readout (valid/ready, channel, last, data, avg)
//   win_id             index of the window held in the shadow
//   overrun            sticky: a window ended while the shadow was still draining
//   overrun_cnt        dropped windows, saturating
module alg_amba_vip_base_stats_window_ctrl #(
    parameter int unsigned NB_CH     = 4,
    parameter int unsigned WIN_WIDTH = 32,
    localparam int unsigned CH_W     = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WIN_WIDTH-1:0]  cfg_window_len,
    input  logic                  cfg_single,
    input  logic                  start,
    input  logic                  stop,
    input  logic [NB_CH*64-1:0]   st_delay_total,
    input  logic [NB_CH*56-1:0]   st_nb_request,
    input  logic [NB_CH*4-1:0]    st_err,
    output logic [NB_CH-1:0]      cnt_rst,
    output logic                  running,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [CH_W-1:0]       rd_ch,
    output logic                  rd_last,
    output logic [63:0]           rd_delay_total,
    output logic [55:0]           rd_nb_request,
    output logic [3:0]            rd_err,
    output logic [63:0]           rd_avg,
    output logic [15:0]           win_id,
    output logic                  overrun,
    output logic [15:0]           overrun_cnt
);

    typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

    state_e               state_q, state_d;
    logic [WIN_WIDTH-1:0] len_q, len_d;
    logic [WIN_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic                 single_q, single_d;
    logic                 pulse_rst;
    logic                 win_end;
    logic                 start_acc;
    logic [NB_CH-1:0]     cnt_rst_q;

    // Shadow and drain state
    logic [63:0]          sh_total [NB_CH];
    logic [55:0]          sh_req   [NB_CH];
    logic [3:0]           sh_err   [NB_CH];
    logic                 busy_q;
    logic [CH_W-1:0]      rd_ch_q;
    logic [15:0]          win_id_q;
    logic                 overrun_q;
    logic [15:0]          overrun_cnt_q;

    logic                 xfer;
    logic                 last_xfer;
    logic                 shadow_free;
    logic                 capture;
    logic                 drop;
    logic [63:0]          cur_total;
    logic [55:0]          cur_req;

    //------------------------------------------------------------------
    // Window FSM
    //------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        single_d  = single_q;
        win_cnt_d = win_cnt_q;
        pulse_rst = 1'b0;
        win_end   = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    start_acc = 1'b1;
                    len_d     = (cfg_window_len == '0) ? WIN_WIDTH'(1) : cfg_window_len;
                    single_d  = cfg_single;
                    pulse_rst = 1'b1;
                    state_d   = StClear;
                end
            end
            StClear: begin
                win_cnt_d = '0;
                state_d   = stop ? StIdle : StRun;
            end
            StRun: begin
                if (stop) begin
                    pulse_rst = 1'b1;
                    win_cnt_d = '0;
                    state_d   = StIdle;
                end else if (win_cnt_q == len_q - WIN_WIDTH'(1)) begin
                    win_end   = 1'b1;
                    pulse_rst = 1'b1;
                    win_cnt_d = '0;
                    if (single_q) begin
                        state_d = StIdle;
                    end
                end else begin
                    win_cnt_d = win_cnt_q + WIN_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            len_q     <= WIN_WIDTH'(1);
            single_q  <= 1'b0;
            win_cnt_q <= '0;
            cnt_rst_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            single_q  <= single_d;
            win_cnt_q <= win_cnt_d;
            cnt_rst_q <= {NB_CH{pulse_rst}};
        end
    end

    assign cnt_rst = cnt_rst_q;
    assign running = (state_q == StClear) || (state_q == StRun);

    //------------------------------------------------------------------
    // Capture and drain
    //------------------------------------------------------------------
    assign xfer        = rd_valid && rd_ready;
    assign last_xfer   = xfer && rd_last;
    // Freeing on the last handshake lets a capture at the same edge succeed.
    assign shadow_free = !busy_q || last_xfer;
    assign capture     = win_end && shadow_free;
    assign drop        = win_end && !shadow_free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NB_CH); i++) begin
                sh_total[i] <= '0;
                sh_req[i]   <= '0;
                sh_err[i]   <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < int'(NB_CH); i++) begin
                sh_total[i] <= st_delay_total[64*i +: 64];
                sh_req[i]   <= st_nb_request[56*i +: 56];
                sh_err[i]   <= st_err[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q        <= 1'b0;
            rd_ch_q       <= '0;
            win_id_q      <= '0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            if (capture) begin
                busy_q <= 1'b1;
            end else if (last_xfer) begin
                busy_q <= 1'b0;
            end

            if (capture || last_xfer) begin
                rd_ch_q <= '0;
            end else if (xfer) begin
                rd_ch_q <= rd_ch_q + CH_W'(1);
            end

            if (start_acc) begin
                win_id_q      <= '0;
                overrun_q     <= 1'b0;
                overrun_cnt_q <= '0;
            end else begin
                if (capture) begin
                    win_id_q <= win_id_q + 16'd1;
                end
                if (drop) begin
                    overrun_q <= 1'b1;
                    if (overrun_cnt_q != 16'hFFFF) begin
                        overrun_cnt_q <= overrun_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    assign cur_total      = sh_total[rd_ch_q];
    assign cur_req        = sh_req[rd_ch_q];
    assign rd_ch          = rd_ch_q;
    assign rd_last        = rd_valid && (rd_ch_q == CH_W'(NB_CH - 1));
    assign rd_delay_total = cur_total;
    assign rd_nb_request  = cur_req;
    assign rd_err         = sh_err[rd_ch_q];
    assign win_id         = win_id_q;
    assign overrun        = overrun_q;
    assign overrun_cnt    = overrun_cnt_q;

`ifdef ALG_STATS_WIN_AVG_EN
    //------------------------------------------------------------------
    // Serial restoring divider. Step 0 loads the current channel, steps
    // 1..64 each produce one quotient bit, and the word is valid at 65.
    //------------------------------------------------------------------
    logic [6:0]  div_cnt_q;
    logic [63:0] div_quo_q;
    logic [63:0] div_rem_q;
    logic [64:0] rem_shift;
    logic [64:0] divisor;
    logic        rem_ge;

    assign rem_shift = {div_rem_q, div_quo_q[63]};
    assign divisor   = {9'd0, cur_req};
    assign rem_ge    = (rem_shift >= divisor);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q <= '0;
            div_quo_q <= '0;
            div_rem_q <= '0;
        end else if (capture || (xfer && !rd_last)) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == 7'd0) begin
            div_quo_q <= cur_total;
            div_rem_q <= '0;
            div_cnt_q <= 7'd1;
        end else if (div_cnt_q <= 7'd64) begin
            div_rem_q <= rem_ge ? 64'(rem_shift - divisor) : rem_shift[63:0];
            div_quo_q <= {div_quo_q[62:0], rem_ge};
            div_cnt_q <= div_cnt_q + 7'd1;
        end
    end

    assign rd_valid = busy_q && (div_cnt_q == 7'd65);
    // A zero request count would yield all-ones; report 0 instead.
    assign rd_avg   = (rd_valid && (cur_req != '0)) ? div_quo_q : 64'd0;
`else
    assign rd_valid = busy_q;
    assign rd_avg   = 64'd0;
`endif

endmodule

// File: tb/tb_alg_amba_vip_base_stats_window_ctrl.sv
// Self-checking bench for alg_amba_vip_base_stats_window_ctrl (default build).
// A queue-based reference model tracks elapsed cycles since start and the list
// of pending snapshot words; every cycle the DUT outputs are compared with it.
module tb_alg_amba_vip_base_stats_window_ctrl;

    localparam int NB_CH = 4;
    localparam int WW    = 32;

    logic               clk = 1'b0;
    logic               rstn;
    logic [WW-1:0]      cfg_window_len;
    logic               cfg_single;
    logic               start;
    logic               stop;
    logic [NB_CH*64-1:0] st_delay_total;
    logic [NB_CH*56-1:0] st_nb_request;
    logic [NB_CH*4-1:0]  st_err;
    logic [NB_CH-1:0]   cnt_rst;
    logic               running;
    logic               rd_valid;
    logic               rd_ready;
    logic [1:0]         rd_ch;
    logic               rd_last;
    logic [63:0]        rd_delay_total;
    logic [55:0]        rd_nb_request;
    logic [3:0]         rd_err;
    logic [63:0]        rd_avg;
    logic [15:0]        win_id;
    logic               overrun;
    logic [15:0]        overrun_cnt;

    always #5 clk = ~clk;

    alg_amba_vip_base_stats_window_ctrl #(
        .NB_CH     (NB_CH),
        .WIN_WIDTH (WW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_window_len (cfg_window_len),
        .cfg_single     (cfg_single),
        .start          (start),
        .stop           (stop),
        .st_delay_total (st_delay_total),
        .st_nb_request  (st_nb_request),
        .st_err         (st_err),
        .cnt_rst        (cnt_rst),
        .running        (running),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_ch          (rd_ch),
        .rd_last        (rd_last),
        .rd_delay_total (rd_delay_total),
        .rd_nb_request  (rd_nb_request),
        .rd_err         (rd_err),
        .rd_avg         (rd_avg),
        .win_id         (win_id),
        .overrun        (overrun),
        .overrun_cnt    (overrun_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    //------------------------------------------------------------------
    // Reference model
    //------------------------------------------------------------------
    typedef struct {
        int          ch;
        logic [63:0] tot;
        logic [55:0] req;
        logic [3:0]  err;
    } word_t;

    word_t  mq[$];      // pending snapshot words, head is the current one
    longint m_el;       // cycles since start (0 = clear cycle), -1 when idle
    longint m_len;
    bit     m_single;
    bit     m_crst;
    int     m_win_id;
    bit     m_ovr;
    int     m_ovc;

    task automatic model_reset();
        mq.delete();
        m_el     = -1;
        m_len    = 1;
        m_single = 1'b0;
        m_crst   = 1'b0;
        m_win_id = 0;
        m_ovr    = 1'b0;
        m_ovc    = 0;
    endtask

    // Advance the model across one clock edge using the inputs driven now.
    task automatic model_step(input bit s, input bit p, input bit r);
        bit hs;
        bit nxt_crst;
        bit end_win;
        hs       = (mq.size() > 0) && r;
        nxt_crst = 1'b0;
        end_win  = 1'b0;
        if (m_el < 0) begin
            if (s) begin
                m_len    = (cfg_window_len == 0) ? 1 : longint'(cfg_window_len);
                m_single = cfg_single;
                m_el     = 0;
                nxt_crst = 1'b1;
                m_win_id = 0;
                m_ovr    = 1'b0;
                m_ovc    = 0;
            end
        end else if (p) begin
            if (m_el > 0) nxt_crst = 1'b1;
            m_el = -1;
        end else if (m_el == 0) begin
            m_el = 1;
        end else if ((m_el - 1) % m_len == m_len - 1) begin
            end_win  = 1'b1;
            nxt_crst = 1'b1;
            m_el     = m_single ? -1 : m_el + 1;
        end else begin
            m_el = m_el + 1;
        end
        if (hs) void'(mq.pop_front());
        if (end_win) begin
            if (mq.size() == 0) begin
                for (int i = 0; i < NB_CH; i++) begin
                    word_t w;
                    w.ch  = i;
                    w.tot = st_delay_total[64*i +: 64];
                    w.req = st_nb_request[56*i +: 56];
                    w.err = st_err[4*i +: 4];
                    mq.push_back(w);
                end
                m_win_id = (m_win_id + 1) % 65536;
            end else begin
                m_ovr = 1'b1;
                if (m_ovc < 65535) m_ovc++;
            end
        end
        m_crst = nxt_crst;
    endtask

    task automatic model_compare();
        check("running", running, m_el >= 0);
        check("cnt_rst", cnt_rst, m_crst ? 64'hF : 64'h0);
        check("rd_valid", rd_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("rd_ch", rd_ch, mq[0].ch);
            check("rd_last", rd_last, mq[0].ch == NB_CH - 1);
            check("rd_delay_total", rd_delay_total, mq[0].tot);
            check("rd_nb_request", rd_nb_request, mq[0].req);
            check("rd_err", rd_err, mq[0].err);
        end
        check("win_id", win_id, m_win_id);
        check("overrun", overrun, m_ovr);
        check("overrun_cnt", overrun_cnt, m_ovc);
        check("rd_avg", rd_avg, 0);
    endtask

    // Drive one cycle's inputs (at negedge), step model, check next cycle.
    task automatic cycle(input bit s, input bit p, input bit r);
        start    = s;
        stop     = p;
        rd_ready = r;
        for (int i = 0; i < NB_CH; i++) begin
            st_delay_total[64*i +: 64] = {$urandom(), $urandom()};
            st_nb_request[56*i +: 56]  = 56'({$urandom(), $urandom()});
            st_err[4*i +: 4]           = 4'($urandom());
        end
        model_step(s, p, r);
        @(posedge clk);
        @(negedge clk);
        model_compare();
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        rd_ready       = 1'b0;
        cfg_window_len = '0;
        cfg_single     = 1'b0;
        st_delay_total = '0;
        st_nb_request  = '0;
        st_err         = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst running", running, 0);
        check("rst cnt_rst", cnt_rst, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_ch", rd_ch, 0);
        check("rst rd_last", rd_last, 0);
        check("rst rd_delay_total", rd_delay_total, 0);
        check("rst rd_nb_request", rd_nb_request, 0);
        check("rst rd_err", rd_err, 0);
        check("rst win_id", win_id, 0);
        check("rst overrun", overrun, 0);
        check("rst overrun_cnt", overrun_cnt, 0);
        rstn = 1'b1;
    endtask

    //------------------------------------------------------------------
    // Directed vector table: state observed k+1 cycles after start
    //------------------------------------------------------------------
    typedef struct {
        int len;
        bit single;
        bit ready;
        int k;
        int exp_win_id;
        bit exp_ovr;
        int exp_ovc;
        bit exp_run;
        bit exp_valid;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{len: 10, single: 1, ready: 1, k: 15, exp_win_id: 1, exp_ovr: 0,
                    exp_ovc: 0, exp_run: 0, exp_valid: 0};
        vecs[1] = '{len: 4, single: 0, ready: 0, k: 13, exp_win_id: 1, exp_ovr: 1,
                    exp_ovc: 2, exp_run: 1, exp_valid: 1};
        vecs[2] = '{len: 0, single: 0, ready: 0, k: 10, exp_win_id: 1, exp_ovr: 1,
                    exp_ovc: 8, exp_run: 1, exp_valid: 1};
        vecs[3] = '{len: 3, single: 1, ready: 0, k: 10, exp_win_id: 1, exp_ovr: 0,
                    exp_ovc: 0, exp_run: 0, exp_valid: 1};
        // Capture edges coincide with the last handshake: never an overrun.
        vecs[4] = '{len: 4, single: 0, ready: 1, k: 13, exp_win_id: 3, exp_ovr: 0,
                    exp_ovc: 0, exp_run: 1, exp_valid: 1};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            cfg_window_len = WW'(vecs[v].len);
            cfg_single     = vecs[v].single;
            cycle(1'b1, 1'b0, vecs[v].ready);
            repeat (vecs[v].k) cycle(1'b0, 1'b0, vecs[v].ready);
            check($sformatf("vec%0d win_id", v), win_id, vecs[v].exp_win_id);
            check($sformatf("vec%0d overrun", v), overrun, vecs[v].exp_ovr);
            check($sformatf("vec%0d overrun_cnt", v), overrun_cnt, vecs[v].exp_ovc);
            check($sformatf("vec%0d running", v), running, vecs[v].exp_run);
            check($sformatf("vec%0d rd_valid", v), rd_valid, vecs[v].exp_valid);
        end

        // Stop mid-window, then restart clears win_id.
        do_reset();
        cfg_window_len = 1;
        cfg_single     = 1'b1;
        cycle(1'b1, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 1'b1);
        check("stop pre win_id", win_id, 1);
        cfg_window_len = 8;
        cfg_single     = 1'b0;
        cycle(1'b1, 1'b0, 1'b1);
        check("stop start win_id", win_id, 0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("stop cnt_rst", cnt_rst, 4'hF);
        check("stop running", running, 0);
        check("stop rd_valid", rd_valid, 0);
        cycle(1'b0, 1'b0, 1'b1);
        check("stop cnt_rst end", cnt_rst, 0);
        cfg_window_len = 2;
        cycle(1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        check("restart win_id", win_id, 1);

        // Back-pressure: ready toggling, 4 words in 8 cycles.
        begin
            int hs;
            int waited;
            do_reset();
            cfg_window_len = 2;
            cfg_single     = 1'b1;
            cycle(1'b1, 1'b0, 1'b0);
            waited = 0;
            while (!rd_valid && waited < 20) begin
                cycle(1'b0, 1'b0, 1'b0);
                waited++;
            end
            check("bp valid seen", rd_valid, 1);
            hs = 0;
            for (int i = 0; i < 8; i++) begin
                if (rd_valid && (i % 2 == 1)) hs++;
                cycle(1'b0, 1'b0, i % 2 == 1);
            end
            check("bp words", hs, 4);
            check("bp drained", rd_valid, 0);
        end

        // Asynchronous reset mid-drain with overrun set.
        do_reset();
        cfg_window_len = 1;
        cfg_single     = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        check("arst pre overrun", overrun, 1);
        rstn = 1'b0;
        #1;
        check("arst rd_valid", rd_valid, 0);
        check("arst running", running, 0);
        check("arst overrun", overrun, 0);
        check("arst overrun_cnt", overrun_cnt, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cfg_window_len = WW'($urandom_range(0, 6));
            cfg_single     = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0);
        end

        // len=0 with a stalled drain: overrun_cnt saturates.
        do_reset();
        cfg_window_len = 0;
        cfg_single     = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (65540) cycle(1'b0, 1'b0, 1'b0);
        check("sat overrun_cnt", overrun_cnt, 16'hFFFF);
        cycle(1'b0, 1'b0, 1'b0);
        check("sat hold", overrun_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
